combination_lock_seq: RTL and testbench

- Parametrised successor to the single-step rotary lock FSM: accepts a multi-digit code, one digit per Enter keypress, and compares against a stored code.
- Adds failed-attempt counting, timed lockout, entry timeout and auto-relock.
- Sits behind the existing per-key synchronizers; drives lock LEDs and a debug state bus.

---
 rtl/combination_lock_seq_pkg.sv | 15 +
 rtl/combination_lock_seq_key_edge.sv | 27 ++
 rtl/combination_lock_seq.sv | 204 ++++++++++++++++++++
 tb/tb_combination_lock_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/combination_lock_seq_pkg.sv
// Shared state encoding for the multi-digit combination lock.
// The numeric values are visible on the debug header, so keep them stable.
package combination_lock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        LOCKED  = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_e;

endpackage

// File: rtl/combination_lock_seq_key_edge.sv
// Rising-edge detector for one already-synchronized key level.
// The history register comes out of reset high, so a key that is held down
// while reset is released is not mistaken for a fresh press.
module key_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_press
);

    logic r_prev;
    logic r_press;

    // Remember the previous level and register a one-cycle press pulse on a 0->1 change
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_press <= i_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/combination_lock_seq.sv
// Multi-digit combination lock: one digit per Enter press, compared against a
// code snapshot taken at the first press. Counts consecutive failures, locks
// the keypad out after too many, discards stale entries and can auto-relock.
module combination_lock_seq
    import combination_lock_pkg::*;
#(
    parameter int DIGIT_W            = 4,
    parameter int NUM_DIGITS         = 4,
    parameter int MAX_TRIES          = 3,
    parameter int LOCKOUT_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES     = 500,
    parameter int AUTO_RELOCK_CYCLES = 0
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Enter,
    input  logic                               Clear,
    input  logic                               Relock,
    input  logic [DIGIT_W-1:0]                 Digit,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]      Code,
    output logic                               Unlocked,
    output logic                               Lockout,
    output logic                               Error,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    Progress,
    output logic [$clog2(MAX_TRIES+1)-1:0]     FailCount,
    output logic [STATE_W-1:0]                 State
);

    localparam int PROG_W  = $clog2(NUM_DIGITS + 1);
    localparam int FC_W    = $clog2(MAX_TRIES + 1);
    localparam int CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int LOCK_TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IDLE_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam bit AR_EN   = (AUTO_RELOCK_CYCLES > 0);
    localparam int AR_TW   = AR_EN ? $clog2(AUTO_RELOCK_CYCLES + 1) : 1;

    localparam logic [PROG_W-1:0]  PROG_LAST = PROG_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]    FC_MAX    = FC_W'(MAX_TRIES);
    localparam logic [LOCK_TW-1:0] LOCK_LAST = LOCK_TW'(LOCKOUT_CYCLES - 1);
    localparam logic [LOCK_TW-1:0] LOCK_MAX  = LOCK_TW'(LOCKOUT_CYCLES);
    localparam logic [IDLE_TW-1:0] IDLE_LAST = IDLE_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_TW-1:0] IDLE_MAX  = IDLE_TW'(TIMEOUT_CYCLES);
    localparam logic [AR_TW-1:0]   AR_LAST   = AR_TW'(AR_EN ? AUTO_RELOCK_CYCLES - 1 : 0);
    localparam logic [AR_TW-1:0]   AR_MAX    = AR_TW'(AR_EN ? AUTO_RELOCK_CYCLES : 1);

    lock_state_e          r_state;
    logic [PROG_W-1:0]    r_progress;
    logic [FC_W-1:0]      r_failCount;
    logic                 r_unlocked;
    logic                 r_lockout;
    logic                 r_error;
    logic                 r_match;
    logic [CODE_W-1:0]    r_shadow;
    logic [LOCK_TW-1:0]   r_lockTimer;
    logic [IDLE_TW-1:0]   r_idleTimer;
    logic [AR_TW-1:0]     r_dwellTimer;

    logic                 w_enterP;
    logic                 w_clearP;
    logic                 w_relockP;
    logic [DIGIT_W-1:0]   w_shadowDigit;
    logic                 w_firstMatch;
    logic                 w_entryMatch;
    logic                 w_evalNow;
    logic                 w_evalMatch;

    key_edge u_enterEdge (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_level (Enter),
        .o_press (w_enterP)
    );

    key_edge u_clearEdge (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_level (Clear),
        .o_press (w_clearP)
    );

    key_edge u_relockEdge (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_level (Relock),
        .o_press (w_relockP)
    );

    // Pick the expected digit for the current position and decide whether this press finishes the code
    always_comb begin
        w_shadowDigit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(r_progress) == i) begin
                w_shadowDigit = r_shadow[(NUM_DIGITS - 1 - i) * DIGIT_W +: DIGIT_W];
            end
        end
        w_firstMatch = (Digit == Code[CODE_W-1 -: DIGIT_W]);
        w_entryMatch = r_match && (Digit == w_shadowDigit);
        w_evalNow    = ((r_state == LOCKED) && w_enterP && (NUM_DIGITS == 1)) ||
                       ((r_state == ENTRY) && w_enterP && !w_clearP && (r_progress == PROG_LAST));
        w_evalMatch  = (r_state == LOCKED) ? w_firstMatch : w_entryMatch;
    end

    // Lock FSM with its shadow code, counters, timers and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= LOCKED;
            r_progress   <= '0;
            r_failCount  <= '0;
            r_unlocked   <= 1'b0;
            r_lockout    <= 1'b0;
            r_error      <= 1'b0;
            r_match      <= 1'b0;
            r_shadow     <= '0;
            r_lockTimer  <= '0;
            r_idleTimer  <= '0;
            r_dwellTimer <= '0;
        end else begin
            r_error <= 1'b0;
            if (w_evalNow) begin
                if (r_state == LOCKED) begin
                    r_shadow <= Code;
                end
                r_progress <= '0;
                if (w_evalMatch) begin
                    r_state      <= OPEN;
                    r_unlocked   <= 1'b1;
                    r_failCount  <= '0;
                    r_dwellTimer <= '0;
                end else begin
                    r_state     <= FAIL;
                    r_error     <= 1'b1;
                    r_failCount <= r_failCount + FC_W'(1);
                end
            end else begin
                case (r_state)
                    LOCKED: begin
                        if (w_enterP) begin
                            r_shadow    <= Code;
                            r_match     <= w_firstMatch;
                            r_progress  <= PROG_W'(1);
                            r_idleTimer <= '0;
                            r_state     <= ENTRY;
                        end
                    end
                    ENTRY: begin
                        if (w_clearP) begin
                            r_state    <= LOCKED;
                            r_progress <= '0;
                        end else if (w_enterP) begin
                            r_match     <= w_entryMatch;
                            r_progress  <= r_progress + PROG_W'(1);
                            r_idleTimer <= '0;
                        end else if (r_idleTimer == IDLE_LAST) begin
                            r_state    <= LOCKED;
                            r_progress <= '0;
                        end else if (r_idleTimer != IDLE_MAX) begin
                            r_idleTimer <= r_idleTimer + IDLE_TW'(1);
                        end
                    end
                    OPEN: begin
                        if (w_relockP || (AR_EN && (r_dwellTimer == AR_LAST))) begin
                            r_state    <= LOCKED;
                            r_unlocked <= 1'b0;
                        end else if (r_dwellTimer != AR_MAX) begin
                            r_dwellTimer <= r_dwellTimer + AR_TW'(1);
                        end
                    end
                    FAIL: begin
                        if (r_failCount == FC_MAX) begin
                            r_state     <= LOCKOUT;
                            r_lockout   <= 1'b1;
                            r_lockTimer <= '0;
                        end else begin
                            r_state <= LOCKED;
                        end
                    end
                    LOCKOUT: begin
                        if (r_lockTimer == LOCK_LAST) begin
                            r_state     <= LOCKED;
                            r_lockout   <= 1'b0;
                            r_failCount <= '0;
                        end else if (r_lockTimer != LOCK_MAX) begin
                            r_lockTimer <= r_lockTimer + LOCK_TW'(1);
                        end
                    end
                    default: begin
                        r_state    <= LOCKED;
                        r_progress <= '0;
                        r_unlocked <= 1'b0;
                        r_lockout  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Unlocked  = r_unlocked;
    assign Lockout   = r_lockout;
    assign Error     = r_error;
    assign Progress  = r_progress;
    assign FailCount = r_failCount;
    assign State     = r_state;

endmodule

// File: tb/tb_combination_lock_seq.sv
// Directed bench for combination_lock_seq using a vector table for the main
// entry/fail/lockout flow and hand-written sequences for the timed corners.
module tb_combination_lock_seq;
    import combination_lock_pkg::*;

    typedef enum int {OP_ENTER, OP_CLEAR, OP_RELOCK, OP_IDLE} op_e;

    typedef struct {
        op_e         op;
        logic [3:0]  digit;
        lock_state_e st;
        logic [2:0]  prog;
        logic        unl;
        logic        lo;
        logic        err;
        logic [1:0]  fc;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic        Enter;
    logic        Clear;
    logic        Relock;
    logic [3:0]  Digit;
    logic [15:0] Code;
    logic        Unlocked;
    logic        Lockout;
    logic        Error;
    logic [2:0]  Progress;
    logic [1:0]  FailCount;
    logic [2:0]  State;

    int vecCount  = 0;
    int missCount = 0;

    vec_t vecs [22];

    combination_lock_seq #(
        .DIGIT_W            (4),
        .NUM_DIGITS         (4),
        .MAX_TRIES          (3),
        .LOCKOUT_CYCLES     (20),
        .TIMEOUT_CYCLES     (50),
        .AUTO_RELOCK_CYCLES (30)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enter     (Enter),
        .Clear     (Clear),
        .Relock    (Relock),
        .Digit     (Digit),
        .Code      (Code),
        .Unlocked  (Unlocked),
        .Lockout   (Lockout),
        .Error     (Error),
        .Progress  (Progress),
        .FailCount (FailCount),
        .State     (State)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance n rising edges and settle 1ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One key action: a level held for one cycle, then released; the FSM reacts on the second edge
    task automatic applyStimulus(input op_e op, input logic [3:0] d);
        case (op)
            OP_ENTER: begin
                Digit = d;
                Enter = 1'b1;
                step(1);
                Enter = 1'b0;
                step(1);
            end
            OP_CLEAR: begin
                Clear = 1'b1;
                step(1);
                Clear = 1'b0;
                step(1);
            end
            OP_RELOCK: begin
                Relock = 1'b1;
                step(1);
                Relock = 1'b0;
                step(1);
            end
            default: step(1);
        endcase
    endtask

    // Compare every output against the expected tuple
    task automatic checkOutput(input string name, input lock_state_e st, input logic [2:0] prog,
                               input logic unl, input logic lo, input logic err, input logic [1:0] fc);
        logic [10:0] act;
        logic [10:0] exp;
        act = {State, Progress, Unlocked, Lockout, Error, FailCount};
        exp = {st, prog, unl, lo, err, fc};
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got state=%0d prog=%0d unl=%b lo=%b err=%b fc=%0d, want state=%0d prog=%0d unl=%b lo=%b err=%b fc=%0d",
                     name, State, Progress, Unlocked, Lockout, Error, FailCount,
                     st, prog, unl, lo, err, fc);
        end
    endtask

    task automatic enterCode(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_ENTER, c[15 - 4*i -: 4]);
        end
    endtask

    initial begin
        // Correct code, ignored keys while open, relock
        vecs[0]  = '{OP_ENTER,  4'h3, ENTRY,   3'd1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{OP_ENTER,  4'hA, ENTRY,   3'd2, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{OP_ENTER,  4'h5, ENTRY,   3'd3, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{OP_ENTER,  4'h1, OPEN,    3'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{OP_ENTER,  4'h7, OPEN,    3'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{OP_CLEAR,  4'h7, OPEN,    3'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{OP_RELOCK, 4'h7, LOCKED,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0};
        // Wrong second digit: no early reject
        vecs[7]  = '{OP_ENTER,  4'h3, ENTRY,   3'd1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{OP_ENTER,  4'hB, ENTRY,   3'd2, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{OP_ENTER,  4'h5, ENTRY,   3'd3, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{OP_ENTER,  4'h1, FAIL,    3'd0, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[11] = '{OP_IDLE,   4'h1, LOCKED,  3'd0, 1'b0, 1'b0, 1'b0, 2'd1};
        // Wrong first digit
        vecs[12] = '{OP_ENTER,  4'h0, ENTRY,   3'd1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[13] = '{OP_ENTER,  4'hA, ENTRY,   3'd2, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[14] = '{OP_ENTER,  4'h5, ENTRY,   3'd3, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[15] = '{OP_ENTER,  4'h1, FAIL,    3'd0, 1'b0, 1'b0, 1'b1, 2'd2};
        vecs[16] = '{OP_IDLE,   4'h1, LOCKED,  3'd0, 1'b0, 1'b0, 1'b0, 2'd2};
        // Wrong last digit: third failure leads to lockout
        vecs[17] = '{OP_ENTER,  4'h3, ENTRY,   3'd1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[18] = '{OP_ENTER,  4'hA, ENTRY,   3'd2, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[19] = '{OP_ENTER,  4'h5, ENTRY,   3'd3, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[20] = '{OP_ENTER,  4'h2, FAIL,    3'd0, 1'b0, 1'b0, 1'b1, 2'd3};
        vecs[21] = '{OP_IDLE,   4'h2, LOCKOUT, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3};

        Enter  = 1'b1;
        Clear  = 1'b0;
        Relock = 1'b0;
        Digit  = 4'h0;
        Code   = 16'h3A51;
        Reset  = 1'b0;

        // Reset values, with Enter held down across reset release
        step(2);
        checkOutput("reset", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        Reset = 1'b1;
        step(3);
        checkOutput("enter_held_through_reset", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        Enter = 1'b0;
        step(2);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].op, vecs[i].digit);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].prog,
                        vecs[i].unl, vecs[i].lo, vecs[i].err, vecs[i].fc);
        end

        // Lockout: Enter ignored, timed exit clears FailCount
        applyStimulus(OP_ENTER, 4'h3);
        checkOutput("lockout_enter_ignored", LOCKOUT, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3);
        step(12);
        checkOutput("lockout_still_active", LOCKOUT, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3);
        step(10);
        checkOutput("lockout_expired", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Auto-relock after the dwell time in OPEN
        enterCode(16'h3A51);
        checkOutput("autorelock_open", OPEN, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        step(20);
        checkOutput("autorelock_still_open", OPEN, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        step(15);
        checkOutput("autorelock_closed", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Entry timeout keeps the failure count
        enterCode(16'h3B51);
        step(1);
        checkOutput("timeout_prefail", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        applyStimulus(OP_ENTER, 4'h3);
        applyStimulus(OP_ENTER, 4'hA);
        step(40);
        checkOutput("timeout_not_yet", ENTRY, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1);
        step(15);
        checkOutput("timeout_expired", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1);

        // Clear and Enter in the same cycle: Clear wins
        applyStimulus(OP_ENTER, 4'h3);
        checkOutput("clear_pre", ENTRY, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1);
        Digit = 4'hA;
        Enter = 1'b1;
        Clear = 1'b1;
        step(1);
        Enter = 1'b0;
        Clear = 1'b0;
        step(1);
        checkOutput("clear_beats_enter", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd1);

        // Code change mid-entry is ignored thanks to the shadow copy
        applyStimulus(OP_ENTER, 4'h3);
        applyStimulus(OP_ENTER, 4'hA);
        Code = 16'h0000;
        applyStimulus(OP_ENTER, 4'h5);
        checkOutput("codechg_third", ENTRY, 3'd3, 1'b0, 1'b0, 1'b0, 2'd1);
        applyStimulus(OP_ENTER, 4'h1);
        checkOutput("codechg_open", OPEN, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(OP_RELOCK, 4'h1);
        checkOutput("codechg_relock", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        Code = 16'h3A51;

        // Reset asserted mid-lockout takes effect without a clock edge
        enterCode(16'h1111);
        step(1);
        enterCode(16'h2222);
        step(1);
        enterCode(16'h4444);
        step(1);
        checkOutput("rst_lockout_entered", LOCKOUT, 3'd0, 1'b0, 1'b1, 1'b0, 2'd3);
        step(5);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("rst_async_mid_lockout", LOCKED, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);
        Reset = 1'b1;
        step(2);
        applyStimulus(OP_ENTER, 4'h3);
        checkOutput("rst_after_release", ENTRY, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
